// File: rtl/mem_types_pkg.sv
// Shared types and constants for the line-to-burst memory adapter.
package mem_types_pkg;

    typedef logic [255:0] line_t;
    typedef logic [63:0]  beat_t;
    typedef logic [31:0]  mask_t;

    localparam int unsigned LINE_OFFSET_BITS = 5;

    // Adapter FSM encoding (plain constants for legacy tool compatibility).
    typedef logic [2:0] adapter_state_e;

    localparam adapter_state_e ST_IDLE     = 3'd0;
    localparam adapter_state_e ST_RD_BURST = 3'd1;
    localparam adapter_state_e ST_MERGE    = 3'd2;
    localparam adapter_state_e ST_WR_BURST = 3'd3;
    localparam adapter_state_e ST_RESP     = 3'd4;
    localparam adapter_state_e ST_HOLDOFF  = 3'd5;

endpackage

// File: rtl/line_beat_buffer.sv
// Line buffer: full-line load, beat-indexed write, byte-masked merge, beat-indexed read.
module line_beat_buffer #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64,
    parameter int unsigned BEATS     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [LINE_BITS-1:0]       load_data,
    input  logic                       beat_we,
    input  logic [$clog2(BEATS)-1:0]   beat_idx,
    input  logic [BEAT_BITS-1:0]       beat_wdata,
    input  logic                       merge_en,
    input  logic [LINE_BITS-1:0]       merge_data,
    input  logic [LINE_BITS/8-1:0]     merge_mask,
    input  logic [$clog2(BEATS)-1:0]   rd_idx,
    output logic [BEAT_BITS-1:0]       rd_beat,
    output logic [LINE_BITS-1:0]       line
);

    logic [LINE_BITS-1:0] buf_q;
    logic [LINE_BITS-1:0] merged;

    // Byte-wise overlay of the pending write data onto the fetched line.
    always_comb begin
        merged = buf_q;
        for (int i = 0; i < LINE_BITS / 8; i++) begin
            if (merge_mask[i]) begin
                merged[8*i +: 8] = merge_data[8*i +: 8];
            end
        end
    end

    // Buffer storage; load, merge and beat write are mutually exclusive by FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else if (load_en) begin
            buf_q <= load_data;
        end else if (merge_en) begin
            buf_q <= merged;
        end else if (beat_we) begin
            buf_q[beat_idx*BEAT_BITS +: BEAT_BITS] <= beat_wdata;
        end
    end

    assign rd_beat = buf_q[rd_idx*BEAT_BITS +: BEAT_BITS];
    assign line    = buf_q;

endmodule

// File: rtl/line_burst_adapter.sv
// Converts 256-bit line read/write requests into 4-beat pmem bursts, with RMW for partial writes.
module line_burst_adapter
    import mem_types_pkg::*;
#(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64,
    parameter int unsigned BEATS     = 4,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_read,
    input  logic                   line_write,
    input  logic [31:0]            line_addr,
    input  logic [LINE_BITS-1:0]   line_wdata,
    input  logic [LINE_BITS/8-1:0] line_wmask,
    output logic                   line_resp,
    output logic [LINE_BITS-1:0]   line_rdata,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [31:0]            pmem_address,
    output logic [BEAT_BITS-1:0]   pmem_wdata,
    input  logic [BEAT_BITS-1:0]   pmem_rdata,
    input  logic                   pmem_resp
);

    localparam int unsigned OFF = $clog2(LINE_BITS / 8);
    localparam int unsigned BW  = $clog2(BEATS);
    localparam int unsigned HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [BW-1:0]  BEAT_LAST = BW'(BEATS - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    adapter_state_e         state;
    logic [BW-1:0]          beat_cnt;
    logic [HCW-1:0]         hold_cnt;
    logic [LINE_BITS-1:0]   wdata_q;
    logic [LINE_BITS/8-1:0] wmask_q;
    logic                   rmw;

    logic accept;
    logic full_write;
    logic unused_addr;

    assign accept      = (state == ST_IDLE) && (line_read || line_write);
    assign full_write  = line_write && (&line_wmask);
    assign unused_addr = ^line_addr[OFF-1:0];

    // FSM, beat/holdoff counters and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            hold_cnt     <= '0;
            pmem_address <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rmw          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pmem_address <= {line_addr[31:OFF], {OFF{1'b0}}};
                        wdata_q      <= line_wdata;
                        wmask_q      <= line_wmask;
                        beat_cnt     <= '0;
                        // Write wins when both are high.
                        rmw          <= line_write && !full_write;
                        state        <= full_write ? ST_WR_BURST : ST_RD_BURST;
                    end
                end
                ST_RD_BURST: begin
                    if (pmem_resp) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_LAST) begin
                            state <= rmw ? ST_MERGE : ST_RESP;
                        end
                    end
                end
                ST_MERGE: begin
                    beat_cnt <= '0;
                    state    <= ST_WR_BURST;
                end
                ST_WR_BURST: begin
                    if (pmem_resp) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_LAST) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    hold_cnt <= '0;
                    state    <= (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    // Requester's registered request lags line_resp; ignore it here.
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state.
    always_comb begin
        pmem_read  = (state == ST_RD_BURST);
        pmem_write = (state == ST_WR_BURST);
        line_resp  = (state == ST_RESP);
    end

    line_beat_buffer #(
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS),
        .BEATS     (BEATS)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (accept && full_write),
        .load_data  (line_wdata),
        .beat_we    (pmem_read && pmem_resp),
        .beat_idx   (beat_cnt),
        .beat_wdata (pmem_rdata),
        .merge_en   (state == ST_MERGE),
        .merge_data (wdata_q),
        .merge_mask (wmask_q),
        .rd_idx     (beat_cnt),
        .rd_beat    (pmem_wdata),
        .line       (line_rdata)
    );

    a_rw_both: assert property (@(posedge clk) disable iff (rst)
        !(state == ST_IDLE && line_read && line_write));
    a_stray_resp: assert property (@(posedge clk) disable iff (rst)
        pmem_resp |-> (state == ST_RD_BURST || state == ST_WR_BURST));
    a_rw_excl: assert property (@(posedge clk) !(pmem_read && pmem_write));

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter with a wait-state pmem model and line-level reference.
module tb_line_burst_adapter;

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic [31:0]  line_wmask;
    logic         line_resp;
    logic [255:0] line_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int tests = 0;
    int fails = 0;

    // pmem model state
    logic [63:0] mem [logic [31:0]];
    logic [63:0] wlog [$];
    int          wait_cycles = 0;
    int          m_wait = 0;
    int          m_beat = 0;
    int          busy = 0;
    int          rd_cycles = 0;
    int          both_hi = 0;
    int          beats_served = 0;
    logic [31:0] last_addr = '0;

    // Reference line memory for the randomized phase
    logic [255:0] ref_mem [logic [31:0]];

    line_burst_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_addr    (line_addr),
        .line_wdata   (line_wdata),
        .line_wmask   (line_wmask),
        .line_resp    (line_resp),
        .line_rdata   (line_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] init_beat(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic [63:0] mem_get(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_beat(a);
    endfunction

    function automatic logic [255:0] pmem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = mem_get(la + 32'(8 * k));
        return l;
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        if (ref_mem.exists(la)) return ref_mem[la];
        for (int k = 0; k < 4; k++) l[64*k +: 64] = init_beat(la + 32'(8 * k));
        return l;
    endfunction

    // pmem responder: drives on negedge, wait_cycles idle cycles before each beat ack
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_beat    = 0;
                m_wait    = 0;
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                busy++;
                if (pmem_read && pmem_write) both_hi++;
                if (pmem_read) rd_cycles++;
                if (m_wait < wait_cycles) begin
                    pmem_resp = 1'b0;
                    m_wait++;
                end else begin
                    m_wait    = 0;
                    pmem_resp = 1'b1;
                    last_addr = pmem_address;
                    if (pmem_read) begin
                        pmem_rdata = mem_get(pmem_address + 32'(8 * m_beat));
                    end else begin
                        mem[pmem_address + 32'(8 * m_beat)] = pmem_wdata;
                        wlog.push_back(pmem_wdata);
                    end
                    beats_served++;
                    m_beat = (m_beat == 3) ? 0 : m_beat + 1;
                end
            end else begin
                pmem_resp = 1'b0;
                m_wait    = 0;
            end
        end
    end

    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                          input logic [31:0] wm, input int hold,
                          output int lat, output logic [255:0] rd, output int extra);
        bit got;
        repeat (3) @(posedge clk);
        #1;
        line_read  = !wr;
        line_write = wr;
        line_addr  = addr;
        line_wdata = wd;
        line_wmask = wm;
        got   = 1'b0;
        lat   = 0;
        extra = 0;
        while (!got && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            got = line_resp;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL txn_timeout addr=%h no line_resp within %0d cycles", addr, lat);
        end
        rd = line_rdata;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (line_resp) extra++;
        end
        line_read  = 1'b0;
        line_write = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (line_resp) extra++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (line_resp !== 1'b0) begin fails++; $display("FAIL rst_line_resp got=%b exp=0", line_resp); end
        tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL rst_pmem_read got=%b exp=0", pmem_read); end
        tests++; if (pmem_write !== 1'b0) begin fails++; $display("FAIL rst_pmem_write got=%b exp=0", pmem_write); end
        tests++; if (pmem_address !== 32'h0) begin fails++; $display("FAIL rst_pmem_address got=%h exp=0", pmem_address); end
        tests++; if (pmem_wdata !== 64'h0) begin fails++; $display("FAIL rst_pmem_wdata got=%h exp=0", pmem_wdata); end
        tests++; if (line_rdata !== 256'h0) begin fails++; $display("FAIL rst_line_rdata got=%h exp=0", line_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_read();
        int lat, extra;
        logic [255:0] rd;
        logic [255:0] exp;
        exp = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        for (int k = 0; k < 4; k++) mem[32'h1220 + 32'(8 * k)] = 64'hA0 + 64'(k);
        wait_cycles = 0;
        do_txn(1'b0, 32'h0000_1234, '0, '0, 0, lat, rd, extra);
        tests++; if (lat != 5) begin fails++; $display("FAIL read_latency got=%0d exp=5", lat); end
        tests++; if (rd !== exp) begin fails++; $display("FAIL read_data got=%h exp=%h", rd, exp); end
        tests++; if (last_addr !== 32'h0000_1220) begin fails++; $display("FAIL read_addr got=%h exp=00001220", last_addr); end
        tests++; if (line_rdata !== exp) begin fails++; $display("FAIL read_rdata_held got=%h exp=%h", line_rdata, exp); end
    endtask

    task automatic test_full_write();
        int lat, extra, rd0;
        logic [255:0] rd;
        logic [255:0] wd;
        wd = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
        wait_cycles = 0;
        wlog.delete();
        rd0 = rd_cycles;
        do_txn(1'b1, 32'h0000_2040, wd, '1, 0, lat, rd, extra);
        tests++; if (lat != 5) begin fails++; $display("FAIL fullwr_latency got=%0d exp=5", lat); end
        tests++; if (rd_cycles != rd0) begin fails++; $display("FAIL fullwr_no_read got=%0d exp=%0d", rd_cycles, rd0); end
        tests++; if (wlog.size() != 4) begin fails++; $display("FAIL fullwr_beats got=%0d exp=4", wlog.size()); end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            tests++;
            if (wlog[k] !== wd[64*k +: 64]) begin
                fails++; $display("FAIL fullwr_beat%0d got=%h exp=%h", k, wlog[k], wd[64*k +: 64]);
            end
        end
        tests++; if (rd !== wd) begin fails++; $display("FAIL fullwr_rdata got=%h exp=%h", rd, wd); end
    endtask

    task automatic test_partial_write();
        int lat, extra;
        logic [255:0] rd;
        logic [255:0] wd;
        logic [255:0] exp;
        for (int k = 0; k < 4; k++) mem[32'h3000 + 32'(8 * k)] = 64'h5555_5555_5555_5555;
        wd = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), 32'hDEAD_BEEF};
        exp = {{3{64'h5555_5555_5555_5555}}, 64'h5555_5555_DEAD_BEEF};
        wait_cycles = 0;
        do_txn(1'b1, 32'h0000_3000, wd, 32'h0000_000F, 0, lat, rd, extra);
        tests++; if (lat != 10) begin fails++; $display("FAIL partwr_latency got=%0d exp=10", lat); end
        tests++; if (pmem_line(32'h3000) !== exp) begin fails++; $display("FAIL partwr_mem got=%h exp=%h", pmem_line(32'h3000), exp); end
        tests++; if (rd !== exp) begin fails++; $display("FAIL partwr_rdata got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_holdoff();
        int lat, extra, b0, busy0;
        logic [255:0] rd;
        wait_cycles = 0;
        b0 = beats_served;
        do_txn(1'b0, 32'h0000_1220, '0, '0, 2, lat, rd, extra);
        busy0 = busy;
        repeat (4) @(posedge clk);
        #1;
        tests++; if (beats_served - b0 != 4) begin fails++; $display("FAIL holdoff_beats got=%0d exp=4", beats_served - b0); end
        tests++; if (extra != 0) begin fails++; $display("FAIL holdoff_extra_resp got=%0d exp=0", extra); end
        tests++; if (busy != busy0) begin fails++; $display("FAIL holdoff_pmem_idle got=%0d exp=%0d", busy, busy0); end
    endtask

    task automatic test_wait_states();
        int lat, extra, rd0;
        logic [255:0] rd;
        logic [255:0] exp;
        for (int k = 0; k < 4; k++) begin
            exp[64*k +: 64] = {$urandom(), $urandom()};
            mem[32'h4000 + 32'(8 * k)] = exp[64*k +: 64];
        end
        wait_cycles = 3;
        rd0 = rd_cycles;
        do_txn(1'b0, 32'h0000_4010, '0, '0, 0, lat, rd, extra);
        wait_cycles = 0;
        tests++; if (lat != 17) begin fails++; $display("FAIL wait_latency got=%0d exp=17", lat); end
        tests++; if (rd_cycles - rd0 != 16) begin fails++; $display("FAIL wait_read_held got=%0d exp=16", rd_cycles - rd0); end
        tests++; if (rd !== exp) begin fails++; $display("FAIL wait_data got=%h exp=%h", rd, exp); end
        tests++; if (extra != 0) begin fails++; $display("FAIL wait_single_resp got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid_burst();
        int n, lat, extra, b0;
        logic [255:0] rd;
        logic [255:0] exp;
        for (int k = 0; k < 4; k++) mem[32'h5000 + 32'(8 * k)] = 64'hC0 + 64'(k);
        wait_cycles = 0;
        repeat (3) @(posedge clk);
        #1;
        b0 = beats_served;
        line_read = 1'b1;
        line_addr = 32'h0000_5008;
        n = 0;
        while (beats_served < b0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++; if (beats_served < b0 + 2) begin fails++; $display("FAIL midrst_start got=%0d exp=%0d", beats_served - b0, 2); end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        line_read = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL midrst_pmem_read got=%b exp=0", pmem_read); end
        tests++; if (line_rdata !== 256'h0) begin fails++; $display("FAIL midrst_rdata got=%h exp=0", line_rdata); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp[64*k +: 64] = 64'hD0 + 64'(k);
            mem[32'h5000 + 32'(8 * k)] = exp[64*k +: 64];
        end
        do_txn(1'b0, 32'h0000_5000, '0, '0, 0, lat, rd, extra);
        tests++; if (lat != 5) begin fails++; $display("FAIL midrst_relatency got=%0d exp=5", lat); end
        tests++; if (rd !== exp) begin fails++; $display("FAIL midrst_redata got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_random();
        bit           wr;
        int           w, sel, lat, extra, exp_lat;
        logic [31:0]  la, addr, wm;
        logic [255:0] wd, old, exp, rd;
        for (int t = 0; t < 24; t++) begin
            wr   = 1'($urandom_range(0, 1));
            la   = 32'h8000 + 32'(32 * $urandom_range(0, 7));
            addr = la | 32'($urandom_range(0, 31));
            wd   = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       wm = '1;
                1:       wm = $urandom();
                2:       wm = 32'h1 << $urandom_range(0, 31);
                default: wm = '0;
            endcase
            w = $urandom_range(0, 2);
            wait_cycles = w;
            old = ref_line(la);
            if (!wr) begin
                exp = old;
            end else begin
                for (int i = 0; i < 32; i++) exp[8*i +: 8] = wm[i] ? wd[8*i +: 8] : old[8*i +: 8];
            end
            exp_lat = (wr && wm != '1) ? 2 + 8 * (w + 1) : 1 + 4 * (w + 1);
            do_txn(wr, addr, wd, wm, 0, lat, rd, extra);
            tests++;
            if (rd !== exp) begin
                fails++; $display("FAIL rand%0d_data wr=%0d mask=%h got=%h exp=%h", t, wr, wm, rd, exp);
            end
            tests++;
            if (lat != exp_lat) begin
                fails++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, exp_lat);
            end
            if (wr) begin
                ref_mem[la] = exp;
                tests++;
                if (pmem_line(la) !== exp) begin
                    fails++; $display("FAIL rand%0d_mem got=%h exp=%h", t, pmem_line(la), exp);
                end
            end
        end
        wait_cycles = 0;
    endtask

    initial begin
        rst        = 1'b1;
        line_read  = 1'b0;
        line_write = 1'b0;
        line_addr  = '0;
        line_wdata = '0;
        line_wmask = '0;
        test_reset();
        test_read();
        test_full_write();
        test_partial_write();
        test_holdoff();
        test_wait_states();
        test_reset_mid_burst();
        test_random();
        tests++;
        if (both_hi != 0) begin fails++; $display("FAIL rw_exclusive got=%0d exp=0", both_hi); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
